control_unit: RTL and testbench

- Multi-cycle instruction sequencer directly upstream of `datapath`.
- Holds PC and IR, and decodes each 16-bit instruction into the datapath control word: DA, AA, BA, MB, FS, MD, RW, plus constant and memory strobes.
- Consumes datapath status flags and the A-bus for branches and jumps.
- Each instruction takes a FETCH cycle then one or more EXEC cycles; load/store holds EXEC until memory acknowledges.

---
 rtl/control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_control_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle instruction sequencer feeding the datapath. Holds PC and IR,
// fetches one 16-bit instruction per FETCH cycle and drives the datapath
// control word during one or more EXEC cycles. LD/ST stay in EXEC until the
// data memory acknowledges. A HALT instruction parks the sequencer until reset.
//
// Optional feature macro: CU_RETIRE_CNT_EN adds a saturating 32-bit retired
// instruction counter on port `retired`.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   instr_in   instruction memory read data for address pc
//   a_bus      datapath A-bus (JMP target)
//   flag_z     datapath zero flag (BRZ condition)
//   flag_n     datapath negative flag (BRN condition)
//   mem_ack    data memory acknowledge for LD/ST
//   pc         instruction fetch address
//   DA/AA/BA   destination / A-port / B-port register addresses
//   MB         B operand select (1 = const_out)
//   FS         function unit select
//   MD         register write-back select (1 = Datain)
//   RW         register file write enable
//   const_out  zero-extended immediate IR[2:0]
//   MW         data memory write request
//   mem_req    data memory request
//   halted     high while in HALT state
//   illegal    one-cycle pulse after an undefined opcode executes
//   retired    (CU_RETIRE_CNT_EN only) completed instruction count
module control_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     instr_in,
    input  logic [15:0]     a_bus,
    input  logic            flag_z,
    input  logic            flag_n,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      DA,
    output logic [2:0]      AA,
    output logic [2:0]      BA,
    output logic            MB,
    output logic [3:0]      FS,
    output logic            MD,
    output logic            RW,
    output logic [15:0]     const_out,
    output logic            MW,
    output logic            mem_req,
    output logic            halted,
    output logic            illegal
`ifdef CU_RETIRE_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [PC_W-1:0] pc_reg;
    logic [15:0]     ir_reg;
    logic            halted_reg;
    logic            illegal_reg;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] dr, sa, sb;
    logic [5:0] offset6;
    logic [PC_W-1:0] offset_ext;

    assign opcode     = ir_reg[15:9];
    assign dr         = ir_reg[8:6];
    assign sa         = ir_reg[5:3];
    assign sb         = ir_reg[2:0];
    assign offset6    = {ir_reg[8:6], ir_reg[2:0]};
    assign offset_ext = {{(PC_W-6){offset6[5]}}, offset6};

    // Opcode classes
    logic is_alu, is_alui, is_ld, is_st, is_brz, is_brn, is_jmp, is_halt, is_undef;

    assign is_alu   = (opcode[6:4] == 3'b000);
    assign is_alui  = (opcode[6:4] == 3'b100);
    assign is_ld    = (opcode == 7'b0010000);
    assign is_st    = (opcode == 7'b0100000);
    assign is_brz   = (opcode == 7'b1100000);
    assign is_brn   = (opcode == 7'b1100001);
    assign is_jmp   = (opcode == 7'b1110000);
    assign is_halt  = (opcode == 7'b1111111);
    assign is_undef = !(is_alu || is_alui || is_ld || is_st ||
                        is_brz || is_brn || is_jmp || is_halt);

    // Memory operations complete only in their ack cycle; everything else
    // (except HALT, handled separately) completes in a single EXEC cycle.
    logic exec_done;
    assign exec_done = !(is_ld || is_st) || mem_ack;

    logic [PC_W-1:0] pc_inc, pc_next;
    assign pc_inc = pc_reg + PC_W'(1);

    always_comb begin
        pc_next = pc_inc;
        if (is_brz && flag_z) begin
            pc_next = pc_reg + offset_ext;
        end else if (is_brn && flag_n) begin
            pc_next = pc_reg + offset_ext;
        end else if (is_jmp) begin
            pc_next = a_bus[PC_W-1:0];
        end
    end

    // Control word: combinational from state and IR. Outside EXEC every
    // field stays at zero, so FETCH and HALT never write anything.
    always_comb begin
        DA        = 3'd0;
        AA        = 3'd0;
        BA        = 3'd0;
        MB        = 1'b0;
        FS        = 4'd0;
        MD        = 1'b0;
        RW        = 1'b0;
        const_out = 16'd0;
        MW        = 1'b0;
        mem_req   = 1'b0;
        if (state_reg == S_EXEC) begin
            if (is_alu || is_alui) begin
                DA = dr;
                AA = sa;
                BA = sb;
                FS = opcode[3:0];
                RW = 1'b1;
                MB = is_alui;
                if (is_alui) begin
                    const_out = {13'd0, sb};
                end
            end else if (is_ld) begin
                DA      = dr;
                AA      = sa;
                MD      = 1'b1;
                mem_req = 1'b1;
                // Register write happens only when the read data is valid.
                RW      = mem_ack;
            end else if (is_st) begin
                AA      = sa;
                BA      = sb;
                mem_req = 1'b1;
                MW      = 1'b1;
            end else if (is_brz || is_brn || is_jmp) begin
                AA = sa;
            end
        end
    end

`ifdef CU_RETIRE_CNT_EN
    logic [31:0] retired_reg;
    assign retired = retired_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= 16'h0000;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef CU_RETIRE_CNT_EN
            retired_reg <= 32'd0;
`endif
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                S_FETCH: begin
                    ir_reg    <= instr_in;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                    end else if (exec_done) begin
                        state_reg   <= S_FETCH;
                        pc_reg      <= pc_next;
                        illegal_reg <= is_undef;
`ifdef CU_RETIRE_CNT_EN
                        if (retired_reg != 32'hFFFF_FFFF) begin
                            retired_reg <= retired_reg + 32'd1;
                        end
`endif
                    end
                end
                default: begin
                    // HALT: frozen until reset
                    state_reg <= S_HALT;
                end
            endcase
        end
    end

    assign pc      = pc_reg;
    assign halted  = halted_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed test-plan steps followed by a random
// instruction stream, checked against an instruction-level reference model.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr_in;
    logic [15:0] a_bus;
    logic        flag_z;
    logic        flag_n;
    logic        mem_ack;
    logic [15:0] pc;
    logic [2:0]  DA, AA, BA;
    logic        MB;
    logic [3:0]  FS;
    logic        MD, RW;
    logic [15:0] const_out;
    logic        MW, mem_req, halted, illegal;
`ifdef CU_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    control_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_in  (instr_in),
        .a_bus     (a_bus),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .DA        (DA),
        .AA        (AA),
        .BA        (BA),
        .MB        (MB),
        .FS        (FS),
        .MD        (MD),
        .RW        (RW),
        .const_out (const_out),
        .MW        (MW),
        .mem_req   (mem_req),
        .halted    (halted),
        .illegal   (illegal)
`ifdef CU_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  da;
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic        mb;
        logic [3:0]  fs;
        logic        md;
        logic        rw;
        logic        mw;
        logic        mreq;
        logic [15:0] k;
    } cw_t;

    localparam int K_ALU  = 0;
    localparam int K_ALUI = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_BRZ  = 4;
    localparam int K_BRN  = 5;
    localparam int K_JMP  = 6;
    localparam int K_HALT = 7;
    localparam int K_NOP  = 8;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_ill;
    logic [31:0] m_retired;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction class from the numeric value of the 7-bit opcode.
    function automatic int classify(input logic [15:0] ir);
        int op;
        op = int'(ir[15:9]);
        if (op < 16) return K_ALU;
        if (op >= 64 && op < 80) return K_ALUI;
        case (op)
            16:      return K_LD;
            32:      return K_ST;
            96:      return K_BRZ;
            97:      return K_BRN;
            112:     return K_JMP;
            127:     return K_HALT;
            default: return K_NOP;
        endcase
    endfunction

    function automatic cw_t expected_cw(input logic [15:0] ir, input logic ack);
        cw_t c;
        int  kind;
        c    = '0;
        kind = classify(ir);
        case (kind)
            K_ALU, K_ALUI: begin
                c.da = ir[8:6]; c.aa = ir[5:3]; c.ba = ir[2:0];
                c.fs = 4'(int'(ir[15:9]) % 16);
                c.rw = 1'b1;
                if (kind == K_ALUI) begin
                    c.mb = 1'b1;
                    c.k  = 16'(int'(ir[2:0]));
                end
            end
            K_LD: begin
                c.da = ir[8:6]; c.aa = ir[5:3];
                c.md = 1'b1; c.mreq = 1'b1; c.rw = ack;
            end
            K_ST: begin
                c.aa = ir[5:3]; c.ba = ir[2:0];
                c.mreq = 1'b1; c.mw = 1'b1;
            end
            K_BRZ, K_BRN, K_JMP: c.aa = ir[5:3];
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic cw_t observed_cw();
        cw_t c;
        c.da = DA; c.aa = AA; c.ba = BA; c.mb = MB; c.fs = FS; c.md = MD;
        c.rw = RW; c.mw = MW; c.mreq = mem_req; c.k = const_out;
        return c;
    endfunction

    function automatic logic [15:0] next_pc(input logic [15:0] p, input logic [15:0] ir,
                                            input logic z, input logic n, input logic [15:0] ab);
        int kind;
        int off;
        kind = classify(ir);
        off  = int'({ir[8:6], ir[2:0]});
        if (off >= 32) off = off - 64;
        case (kind)
            K_BRZ:   return z ? 16'(int'(p) + off) : 16'(int'(p) + 1);
            K_BRN:   return n ? 16'(int'(p) + off) : 16'(int'(p) + 1);
            K_JMP:   return ab;
            K_HALT:  return p;
            default: return 16'(int'(p) + 1);
        endcase
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        m_pc      = 16'h0000;
        m_ill     = 1'b0;
        m_retired = 32'd0;
        chk("reset_pc", 64'(pc), 64'(m_pc));
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_illegal", 64'(illegal), 64'd0);
        chk("reset_cw", 64'(observed_cw()), 64'(cw_t'('0)));
    endtask

    // One full instruction: FETCH cycle, `waits` non-ack cycles for LD/ST,
    // then the completing EXEC cycle. Entry/exit at posedge+1 in FETCH.
    task automatic run_instr(input logic [15:0] ir, input logic z, input logic n,
                             input logic [15:0] ab, input int waits);
        int          kind;
        logic [15:0] npc;
        kind = classify(ir);

        // FETCH: mem_ack and flags are noise here and must be ignored
        instr_in = ir;
        mem_ack  = 1'($urandom);
        flag_z   = 1'($urandom);
        flag_n   = 1'($urandom);
        a_bus    = 16'($urandom);
        #1;
        chk("fetch_pc", 64'(pc), 64'(m_pc));
        chk("fetch_cw", 64'(observed_cw()), 64'(cw_t'('0)));
        chk("fetch_illegal", 64'(illegal), 64'(m_ill));
        chk("fetch_halted", 64'(halted), 64'd0);
        @(posedge clk); #1;

        instr_in = 16'($urandom);
        if (kind == K_LD || kind == K_ST) begin
            for (int w = 0; w < waits; w++) begin
                mem_ack = 1'b0;
                flag_z  = 1'($urandom);
                flag_n  = 1'($urandom);
                #1;
                chk("wait_cw", 64'(observed_cw()), 64'(expected_cw(ir, 1'b0)));
                chk("wait_pc", 64'(pc), 64'(m_pc));
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b1;
        flag_z  = z;
        flag_n  = n;
        a_bus   = ab;
        #1;
        chk("exec_cw", 64'(observed_cw()), 64'(expected_cw(ir, 1'b1)));
        chk("exec_illegal", 64'(illegal), 64'd0);
        @(posedge clk); #1;

        npc = next_pc(m_pc, ir, z, n, ab);
        $display("instr ir=%04h kind=%0d pc=%04h -> %04h waits=%0d", ir, kind, m_pc, npc, waits);
        m_pc  = npc;
        m_ill = (kind == K_NOP);
        if (kind != K_HALT && m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 32'd1;
`ifdef CU_RETIRE_CNT_EN
        chk("retired", 64'(retired), 64'(m_retired));
`endif
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        int          sel;
        r   = 16'($urandom);
        sel = int'($urandom_range(0, 8));
        case (sel)
            0:       r[15:12] = 4'b0000;
            1:       r[15:12] = 4'b1000;
            2:       r[15:9]  = 7'b0010000;
            3:       r[15:9]  = 7'b0100000;
            4:       r[15:9]  = 7'b1100000;
            5:       r[15:9]  = 7'b1100001;
            6:       r[15:9]  = 7'b1110000;
            default: ;
        endcase
        if (r[15:9] == 7'b1111111) r[15:9] = 7'b0110011;
        return r;
    endfunction

    initial begin
        rst_n    = 1'b0;
        instr_in = 16'h0000;
        a_bus    = 16'h0000;
        flag_z   = 1'b0;
        flag_n   = 1'b0;
        mem_ack  = 1'b0;
        @(posedge clk);
        do_reset();

        // ALU reg-reg, immediate, LD with 3 wait cycles, ST
        run_instr(16'h0A5A, 1'b0, 1'b0, 16'h1234, 0);
        chk("alu_pc", 64'(pc), 64'd1);
        run_instr(16'h8A15, 1'b0, 1'b0, 16'h0000, 0);
        run_instr(16'h2088, 1'b0, 1'b0, 16'h0000, 3);
        run_instr(16'h40D3, 1'b0, 1'b0, 16'h0000, 2);

        // Branch offset -3 from pc=10, taken and not taken; JMP
        run_instr(16'hE008, 1'b0, 1'b0, 16'd10, 0);
        run_instr(16'hC1C5, 1'b1, 1'b0, 16'h0000, 0);
        chk("brz_taken", 64'(pc), 64'd7);
        run_instr(16'hE008, 1'b0, 1'b0, 16'd10, 0);
        run_instr(16'hC1C5, 1'b0, 1'b1, 16'h0000, 0);
        chk("brz_not_taken", 64'(pc), 64'd11);
        run_instr(16'hC3C5, 1'b0, 1'b1, 16'h0000, 0);
        run_instr(16'hE010, 1'b0, 1'b0, 16'h0040, 0);
        chk("jmp", 64'(pc), 64'h40);

        // PC wrap at 0xFFFF
        run_instr(16'hE000, 1'b0, 1'b0, 16'hFFFF, 0);
        run_instr(16'h0A5A, 1'b0, 1'b0, 16'h0000, 0);
        chk("pc_wrap", 64'(pc), 64'h0);

        // Undefined opcode from a fresh reset
        do_reset();
        run_instr(16'h6600, 1'b0, 1'b0, 16'h0000, 0);
        chk("illegal_pc", 64'(pc), 64'd1);
        chk("illegal_pulse", 64'(illegal), 64'd1);
`ifdef CU_RETIRE_CNT_EN
        chk("retired_after_illegal", 64'(retired), 64'd1);
`endif

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            run_instr(rand_instr(), 1'($urandom), 1'($urandom), 16'($urandom),
                      int'($urandom_range(0, 3)));
        end

        // HALT, then stay frozen for 20 cycles with noisy inputs
        run_instr(16'hFE00, 1'b0, 1'b0, 16'h0000, 0);
        for (int c = 0; c < 20; c++) begin
            instr_in = 16'($urandom);
            mem_ack  = 1'($urandom);
            flag_z   = 1'($urandom);
            a_bus    = 16'($urandom);
            #1;
            chk("halt_halted", 64'(halted), 64'd1);
            chk("halt_pc", 64'(pc), 64'(m_pc));
            chk("halt_cw", 64'(observed_cw()), 64'(cw_t'('0)));
            @(posedge clk); #1;
        end
        do_reset();
        run_instr(16'h8A15, 1'b0, 1'b0, 16'h0000, 0);
        chk("post_halt_pc", 64'(pc), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
